// File: rtl/cmt_rx_fifo_ctrl_if.sv
// cmt_rx_fifo_ctrl_if
//  Bundles the two buses of the CMT receive FIFO.
//   - Tape-side push port: cmt_data, cmt_stb, and the cmt_busy back-pressure.
//   - Avalon-MM slave port (read latency 1), plus the level irq.
//  Modports:
//   master : the emulated machine and the Nios host (drive strobes and data).
//   slave  : the FIFO controller.
interface cmt_rx_fifo_ctrl_if;
  logic [7:0]  cmt_data;
  logic        cmt_stb;
  logic        cmt_busy;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport master (
    output cmt_data, cmt_stb, avs_address, avs_read, avs_write, avs_writedata,
    input  cmt_busy, avs_readdata, irq
  );

  modport slave (
    input  cmt_data, cmt_stb, avs_address, avs_read, avs_write, avs_writedata,
    output cmt_busy, avs_readdata, irq
  );
endinterface

// File: rtl/cmt_rx_fifo_ctrl.sv
// cmt_rx_fifo_ctrl
//  Receive-side sequencer for cassette save data. Bytes strobed in by the
//  emulated PC-8001 are buffered in a FIFO. Nios firmware drains the FIFO
//  through an Avalon-MM register window, using the level irq to know when.
//  Register map (avs_address):
//   0 DATA    R  [7:0] head byte; the read pops the head. An empty read returns 0.
//   1 STATUS  R  [0] not_empty [1] full [2] overrun [15:8] count
//             W  a 1 written to bit 2 clears overrun.
//   2 CONTROL RW [0] enable [1] irq_en; W [2] flush (self-clearing).
//   3 THRESH  RW [7:0] irq level; the value 0 acts as 1.
//  Ports: clk, reset_n (async, active-low), bus (cmt_rx_fifo_ctrl_if.slave).
module cmt_rx_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  cmt_rx_fifo_ctrl_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  overrun, enable, irq_en;
  logic [7:0]            thresh;

  logic full, empty, pop, push, drop, flush, ovr_clr;
  logic [7:0] count8, thresh_eff, head;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign count8 = 8'(count);
  assign head   = empty ? 8'h00 : mem[rd_ptr];

  assign pop     = bus.avs_read  && (bus.avs_address == 2'd0) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign push    = bus.cmt_stb && enable && (!full || pop);
  assign drop    = bus.cmt_stb && enable && full && !pop;
  assign flush   = bus.avs_write && (bus.avs_address == 2'd2) && bus.avs_writedata[2];
  assign ovr_clr = bus.avs_write && (bus.avs_address == 2'd1) && bus.avs_writedata[2];

  assign thresh_eff   = (thresh == 8'd0) ? 8'd1 : thresh;
  assign bus.cmt_busy = full;

  // The storage array has no reset. A slot is always written before it is read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= bus.cmt_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      overrun          <= 1'b0;
      enable           <= 1'b0;
      irq_en           <= 1'b0;
      thresh           <= 8'd1;
      bus.avs_readdata <= '0;
      bus.irq          <= 1'b0;
    end else begin
      // Flush overrides any push or pop in the same cycle. The byte being pushed is discarded.
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end

      // Flush does not touch the sticky overrun flag. A new drop takes priority over a clear.
      if (drop && !flush) overrun <= 1'b1;
      else if (ovr_clr)   overrun <= 1'b0;

      if (bus.avs_write && bus.avs_address == 2'd2) begin
        enable <= bus.avs_writedata[0];
        irq_en <= bus.avs_writedata[1];
      end
      if (bus.avs_write && bus.avs_address == 2'd3) thresh <= bus.avs_writedata[7:0];

      // The read data shows the state from before this cycle's push or pop.
      if (bus.avs_read) begin
        unique case (bus.avs_address)
          2'd0: bus.avs_readdata <= {24'h0, head};
          2'd1: bus.avs_readdata <= {16'h0, count8, 5'h0, overrun, full, !empty};
          2'd2: bus.avs_readdata <= {30'h0, irq_en, enable};
          default: bus.avs_readdata <= {24'h0, thresh};
        endcase
      end

      bus.irq <= irq_en && ((count8 >= thresh_eff) || overrun);
    end
  end
endmodule

// File: tb/tb_cmt_rx_fifo_ctrl.sv
module tb_cmt_rx_fifo_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cmt_rx_fifo_ctrl_if bus();
  cmt_rx_fifo_ctrl #(.DEPTH_LOG2(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Scoreboard: the expected FIFO contents and the model control state.
  logic [7:0] sb[$];
  logic       en_m = 1'b0;
  logic       ovr_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [7:0] c;
    c = 8'(sb.size());
    return {16'h0, c, 5'h0, ovr_m, sb.size() == 16, sb.size() != 0};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.avs_address = a; bus.avs_writedata = d; bus.avs_write = 1'b1;
    @(posedge clk); #1;
    bus.avs_write = 1'b0;
    if (a == 2'd2) begin
      en_m = d[0];
      if (d[2]) sb.delete();
    end
    if (a == 2'd1 && d[2]) ovr_m = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.avs_address = a; bus.avs_read = 1'b1;
    @(posedge clk); #1;
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic push(input logic [7:0] b);
    bus.cmt_data = b; bus.cmt_stb = 1'b1;
    @(posedge clk); #1;
    bus.cmt_stb = 1'b0;
    if (en_m) begin
      if (sb.size() < 16) sb.push_back(b);
      else ovr_m = 1'b1;
    end
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] d;
    logic [7:0]  e;
    e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    rd(2'd0, d);
    chk(tag, d, {24'h0, e});
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    rd(2'd1, d);
    chk(tag, d, exp_status());
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  e;
    bus.cmt_data = '0; bus.cmt_stb = 1'b0; bus.avs_address = '0;
    bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
    idle(2);
    chk("rst_irq", {31'h0, bus.irq}, 32'h0);
    chk("rst_busy", {31'h0, bus.cmt_busy}, 32'h0);
    chk("rst_rdata", bus.avs_readdata, 32'h0);
    reset_n = 1'b1;
    idle(1);
    rd(2'd1, d); chk("rst_status", d, 32'h0);
    rd(2'd2, d); chk("rst_ctrl", d, 32'h0);
    rd(2'd3, d); chk("rst_thresh", d, 32'h1);

    // Test 1: basic push and pop.
    wr(2'd2, 32'h1);
    push(8'hA5); push(8'h3C);
    rd_data("t1_d0"); rd_data("t1_d1");
    rd(2'd1, d); chk("t1_status", d, 32'h0);

    // Test 2: fill the FIFO, overrun, clear the flag, drain.
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("t2_busy", {31'h0, bus.cmt_busy}, 32'h1);
    rd(2'd1, d); chk("t2_status_full", d, 32'h1003);
    push(8'hEE);
    rd(2'd1, d); chk("t2_status_ovr", d, 32'h1007);
    wr(2'd1, 32'h4);
    chk_status("t2_status_clr");
    for (int i = 0; i < 16; i++) rd_data($sformatf("t2_drain%0d", i));
    rd(2'd1, d); chk("t2_status_empty", d, 32'h0);
    chk("t2_busy0", {31'h0, bus.cmt_busy}, 32'h0);

    // Test 3: push and pop in the same cycle while the FIFO is full.
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    bus.cmt_data = 8'h99; bus.cmt_stb = 1'b1;
    bus.avs_address = 2'd0; bus.avs_read = 1'b1;
    @(posedge clk); #1;
    bus.cmt_stb = 1'b0; bus.avs_read = 1'b0;
    e = sb.pop_front(); sb.push_back(8'h99);
    chk("t3_simul_rd", bus.avs_readdata, {24'h0, e});
    rd(2'd1, d); chk("t3_status", d, 32'h1003);
    for (int i = 0; i < 16; i++) rd_data($sformatf("t3_drain%0d", i));

    // Test 4: threshold interrupt.
    wr(2'd3, 32'h4); wr(2'd2, 32'h3);
    push(8'h01); push(8'h02); push(8'h03);
    idle(1);
    chk("t4_irq_3", {31'h0, bus.irq}, 32'h0);
    push(8'h04);
    idle(1);
    chk("t4_irq_4", {31'h0, bus.irq}, 32'h1);
    rd_data("t4_pop1");
    idle(1);
    chk("t4_irq_pop", {31'h0, bus.irq}, 32'h0);
    rd_data("t4_pop2"); rd_data("t4_pop3");
    wr(2'd3, 32'h0);
    idle(1);
    chk("t4_irq_th0", {31'h0, bus.irq}, 32'h1);
    rd(2'd3, d); chk("t4_thresh_rd", d, 32'h0);

    // Test 5: flush with a coincident strobe, then strobes while disabled.
    wr(2'd2, 32'h1);
    for (int i = 0; i < 7; i++) push(8'h40 + 8'(i));
    chk_status("t5_status8");
    bus.cmt_data = 8'h77; bus.cmt_stb = 1'b1;
    wr(2'd2, 32'h5);
    bus.cmt_stb = 1'b0;
    rd(2'd1, d); chk("t5_status_flush", d, 32'h0);
    rd_data("t5_empty_rd");
    rd(2'd2, d); chk("t5_ctrl_rd", d, 32'h1);
    wr(2'd2, 32'h0);
    push(8'h55);
    rd(2'd1, d); chk("t5_status_dis", d, 32'h0);

    // Test 6: reset in the middle of a burst while irq is high.
    wr(2'd3, 32'h1); wr(2'd2, 32'h3);
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    rd(2'd1, d); chk("t6_pre_status", d, 32'h1003);
    chk("t6_pre_irq", {31'h0, bus.irq}, 32'h1);
    bus.cmt_stb = 1'b1; bus.cmt_data = 8'hFF;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_irq", {31'h0, bus.irq}, 32'h0);
    chk("t6_rst_busy", {31'h0, bus.cmt_busy}, 32'h0);
    chk("t6_rst_rdata", bus.avs_readdata, 32'h0);
    bus.cmt_stb = 1'b0;
    sb.delete(); en_m = 1'b0; ovr_m = 1'b0;
    idle(1);
    reset_n = 1'b1;
    rd(2'd3, d); chk("t6_thresh", d, 32'h1);
    rd(2'd1, d); chk("t6_status", d, 32'h0);
    rd(2'd2, d); chk("t6_ctrl", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
